// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write-back path.
//   WIDTH_DEFAULT : default register/data width
//   VSEL_*        : write-back source select encodings
//   q_state_t     : write-queue occupancy state (value equals entry count)
//   wq_entry_t    : queue entry {num, data} at the default width
// Optional feature macro used by the top: REGFILE_WR_BYPASS_EN.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_t;

    typedef struct packed {
        logic [2:0]               num;
        logic [WIDTH_DEFAULT-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/regfile_wq.sv
// ---------------------------------------------------------------------------
// regfile_wq
// Two-entry FIFO of pending register writes.
// Ports:
//   clk, resetn             : clock, asynchronous active-low reset
//   push, push_num/data     : enqueue request and entry (ignored when FULL)
//   pop                     : dequeue head (ignored when EMPTY)
//   state                   : occupancy (Q_EMPTY / Q_ONE / Q_FULL)
//   head_num/data           : oldest entry
//   tail_num/data           : youngest entry (same as head in Q_ONE)
// ---------------------------------------------------------------------------
module regfile_wq
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [2:0]       push_num,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output q_state_t         state,
    output logic [2:0]       head_num,
    output logic [WIDTH-1:0] head_data,
    output logic [2:0]       tail_num,
    output logic [WIDTH-1:0] tail_data
);

    q_state_t         state_reg, state_next;
    logic [2:0]       slot0_num_reg, slot1_num_reg;
    logic [WIDTH-1:0] slot0_data_reg, slot1_data_reg;

    logic do_push, do_pop;
    logic load0_in, load0_shift, load1_in;

    assign do_push = push && (state_reg != Q_FULL);
    assign do_pop  = pop && (state_reg != Q_EMPTY);

    always_comb begin
        state_next  = state_reg;
        load0_in    = 1'b0;
        load0_shift = 1'b0;
        load1_in    = 1'b0;
        unique case (state_reg)
            Q_EMPTY: begin
                if (do_push) begin
                    load0_in   = 1'b1;
                    state_next = Q_ONE;
                end
            end
            Q_ONE: begin
                unique case ({do_push, do_pop})
                    // Head leaves and the new entry becomes the sole head.
                    2'b11: load0_in = 1'b1;
                    2'b10: begin
                        load1_in   = 1'b1;
                        state_next = Q_FULL;
                    end
                    2'b01: state_next = Q_EMPTY;
                    default: ;
                endcase
            end
            Q_FULL: begin
                if (do_pop) begin
                    load0_shift = 1'b1;
                    state_next  = Q_ONE;
                end
            end
            default: state_next = Q_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= Q_EMPTY;
            slot0_num_reg  <= '0;
            slot0_data_reg <= '0;
            slot1_num_reg  <= '0;
            slot1_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load0_in) begin
                slot0_num_reg  <= push_num;
                slot0_data_reg <= push_data;
            end else if (load0_shift) begin
                slot0_num_reg  <= slot1_num_reg;
                slot0_data_reg <= slot1_data_reg;
            end
            if (load1_in) begin
                slot1_num_reg  <= push_num;
                slot1_data_reg <= push_data;
            end
        end
    end

    assign state     = state_reg;
    assign head_num  = slot0_num_reg;
    assign head_data = slot0_data_reg;
    assign tail_num  = (state_reg == Q_FULL) ? slot1_num_reg  : slot0_num_reg;
    assign tail_data = (state_reg == Q_FULL) ? slot1_data_reg : slot0_data_reg;

endmodule

// File: rtl/regfile_write.sv
// ---------------------------------------------------------------------------
// regfile_write
// Write-back side of the 8 x WIDTH register file: selects the write-back
// value, queues up to two writes and commits one per cycle unless held.
// Ports:
//   clk, resetn         : clock, asynchronous active-low reset
//   write, writenum     : write request and destination register
//   vsel                : source select (c_in / pc / imm8 / mdata)
//   c_in, pc, imm8, mdata : candidate write-back sources
//   hold                : suppress commits this cycle
//   wr_ready, pending   : queue not full / queue not empty
//   regs                : flat register bus, reg i at [i*WIDTH +: WIDTH]
//   rd_num, rd_data     : forwarding read port (REGFILE_WR_BYPASS_EN only)
// Optional feature macro: REGFILE_WR_BYPASS_EN.
// ---------------------------------------------------------------------------
module regfile_write
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               write,
    input  logic [2:0]         writenum,
    input  logic [1:0]         vsel,
    input  logic [WIDTH-1:0]   c_in,
    input  logic [7:0]         pc,
    input  logic [7:0]         imm8,
    input  logic [WIDTH-1:0]   mdata,
    input  logic               hold,
`ifdef REGFILE_WR_BYPASS_EN
    input  logic [2:0]         rd_num,
    output logic [WIDTH-1:0]   rd_data,
`endif
    output logic               wr_ready,
    output logic               pending,
    output logic [8*WIDTH-1:0] regs
);

    q_state_t         q_state;
    logic [2:0]       head_num;
    logic [WIDTH-1:0] head_data;
`ifdef REGFILE_WR_BYPASS_EN
    logic [2:0]       tail_num;
    logic [WIDTH-1:0] tail_data;
`endif
    logic [WIDTH-1:0] wb_data;
    logic             accept;
    logic             commit;
    logic [WIDTH-1:0] regs_reg [8];

    always_comb begin
        wb_data = c_in;
        unique case (vsel)
            VSEL_C:     wb_data = c_in;
            VSEL_PC: begin
                wb_data      = '0;
                wb_data[7:0] = pc;
            end
            VSEL_IMM: begin
                // Fill with the sign bit first, then overlay the low byte;
                // this stays legal down to WIDTH == 8.
                wb_data      = {WIDTH{imm8[7]}};
                wb_data[7:0] = imm8;
            end
            VSEL_MDATA: wb_data = mdata;
            default:    wb_data = c_in;
        endcase
    end

    // wr_ready comes only from registered queue state, so a FULL queue
    // refuses a push even on a cycle where it also commits.
    assign wr_ready = (q_state != Q_FULL);
    assign pending  = (q_state != Q_EMPTY);
    assign accept   = write && wr_ready;
    assign commit   = !hold && (q_state != Q_EMPTY);

    regfile_wq #(
        .WIDTH(WIDTH)
    ) u_wq (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_num  (writenum),
        .push_data (wb_data),
        .pop       (commit),
        .state     (q_state),
        .head_num  (head_num),
        .head_data (head_data),
`ifdef REGFILE_WR_BYPASS_EN
        .tail_num  (tail_num),
        .tail_data (tail_data)
`else
        .tail_num  (),
        .tail_data ()
`endif
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (commit) begin
            regs_reg[head_num] <= head_data;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_regs_out
        assign regs[gi*WIDTH +: WIDTH] = regs_reg[gi];
    end

`ifdef REGFILE_WR_BYPASS_EN
    // Youngest matching queued entry wins: tail overrides head, head
    // overrides the committed value.
    always_comb begin
        rd_data = regs_reg[rd_num];
        if ((q_state != Q_EMPTY) && (head_num == rd_num)) begin
            rd_data = head_data;
        end
        if ((q_state == Q_FULL) && (tail_num == rd_num)) begin
            rd_data = tail_data;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write.sv
// ---------------------------------------------------------------------------
// tb_regfile_write
// Self-checking bench for regfile_write with a scoreboard queue of pending
// writes and a reference copy of the register array.
// Optional feature macro exercised when defined: REGFILE_WR_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_write;

    typedef struct {
        logic [2:0]  num;
        logic [15:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         write;
    logic [2:0]   writenum;
    logic [1:0]   vsel;
    logic [15:0]  c_in;
    logic [7:0]   pc;
    logic [7:0]   imm8;
    logic [15:0]  mdata;
    logic         hold;
    logic         wr_ready;
    logic         pending;
    logic [127:0] regs;
`ifdef REGFILE_WR_BYPASS_EN
    logic [2:0]   rd_num;
    logic [15:0]  rd_data;
`endif

    int errors = 0;
    int checks = 0;

    ent_t        sb[$];
    logic [15:0] exp_regs [8];
    int          commits = 0;

    always #5 clk = ~clk;

    regfile_write #(.WIDTH(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .write    (write),
        .writenum (writenum),
        .vsel     (vsel),
        .c_in     (c_in),
        .pc       (pc),
        .imm8     (imm8),
        .mdata    (mdata),
        .hold     (hold),
`ifdef REGFILE_WR_BYPASS_EN
        .rd_num   (rd_num),
        .rd_data  (rd_data),
`endif
        .wr_ready (wr_ready),
        .pending  (pending),
        .regs     (regs)
    );

    function automatic logic [15:0] sel_val(logic [1:0] s, logic [15:0] c,
                                            logic [7:0] p, logic [7:0] im,
                                            logic [15:0] md);
        case (s)
            2'd0:    return c;
            2'd1:    return {8'h00, p};
            2'd2:    return {{8{im[7]}}, im};
            default: return md;
        endcase
    endfunction

    function automatic logic [127:0] exp_flat();
        logic [127:0] f;
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = exp_regs[i];
        return f;
    endfunction

    function automatic logic [15:0] reg_of(int idx);
        logic [127:0] r;
        r = regs;
        return r[idx*16 +: 16];
    endfunction

    // One clock: predict acceptance/commit from pre-edge state, advance the
    // scoreboard and reference registers, leave time 1 unit past the edge.
    task automatic tick();
        bit   acc, com;
        ent_t e, h;
        acc    = write && (sb.size() < 2);
        com    = !hold && (sb.size() > 0);
        e.num  = writenum;
        e.data = sel_val(vsel, c_in, pc, imm8, mdata);
        @(posedge clk);
        #1;
        if (com) begin
            h = sb.pop_front();
            exp_regs[h.num] = h.data;
            commits++;
            $display("commit r%0d <= %h", h.num, h.data);
        end
        if (acc) begin
            sb.push_back(e);
            $display("accept r%0d <= %h", e.num, e.data);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        clear_model();
        checks++; if (regs !== 128'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
        @(negedge clk);
        resetn = 1'b1;
        tick(); tick();
        checks++; if (regs !== 128'h0) begin errors++; $display("FAIL idle_regs: got %h expected 0", regs); end
    endtask

    task automatic test_vsel();
        write = 1'b1; writenum = 3'd3; vsel = 2'b10; imm8 = 8'hF0;
        tick();
        write = 1'b0;
        checks++; if (reg_of(3) !== 16'h0000) begin errors++; $display("FAIL imm_early: got %h expected 0000", reg_of(3)); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL imm_pending: got %b expected 1", pending); end
        tick();
        checks++; if (reg_of(3) !== 16'hFFF0) begin errors++; $display("FAIL imm_sext: got %h expected FFF0", reg_of(3)); end
        write = 1'b1; vsel = 2'b01; pc = 8'h85;
        tick();
        write = 1'b0;
        tick();
        checks++; if (reg_of(3) !== 16'h0085) begin errors++; $display("FAIL pc_zext: got %h expected 0085", reg_of(3)); end
        write = 1'b1; writenum = 3'd0; vsel = 2'b00; c_in = 16'h1234;
        tick();
        writenum = 3'd7; vsel = 2'b11; mdata = 16'hBEEF;
        tick();
        write = 1'b0;
        tick();
        checks++; if (reg_of(0) !== 16'h1234) begin errors++; $display("FAIL cin_sel: got %h expected 1234", reg_of(0)); end
        checks++; if (reg_of(7) !== 16'hBEEF) begin errors++; $display("FAIL mdata_sel: got %h expected BEEF", reg_of(7)); end
        checks++; if (regs !== exp_flat()) begin errors++; $display("FAIL vsel_regs: got %h expected %h", regs, exp_flat()); end
    endtask

    task automatic test_hold_full();
        hold = 1'b1; write = 1'b1; vsel = 2'b00;
        writenum = 3'd1; c_in = 16'h1111; tick();
        writenum = 3'd2; c_in = 16'h2222; tick();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", wr_ready); end
        writenum = 3'd4; c_in = 16'h4444; tick();
        checks++; if (regs !== exp_flat()) begin errors++; $display("FAIL hold_nocommit: got %h expected %h", regs, exp_flat()); end
        checks++; if (reg_of(4) !== 16'h0000) begin errors++; $display("FAIL full_reject: got %h expected 0000", reg_of(4)); end
        hold = 1'b0;
        tick();
        checks++; if (reg_of(1) !== 16'h1111) begin errors++; $display("FAIL release_r1: got %h expected 1111", reg_of(1)); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", wr_ready); end
        tick();
        write = 1'b0;
        checks++; if (reg_of(2) !== 16'h2222) begin errors++; $display("FAIL release_r2: got %h expected 2222", reg_of(2)); end
        tick();
        checks++; if (reg_of(4) !== 16'h4444) begin errors++; $display("FAIL third_r4: got %h expected 4444", reg_of(4)); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL drain_pending: got %b expected 0", pending); end
        checks++; if (regs !== exp_flat()) begin errors++; $display("FAIL hold_regs: got %h expected %h", regs, exp_flat()); end
    endtask

    task automatic test_same_reg();
        hold = 1'b1; write = 1'b1; vsel = 2'b00; writenum = 3'd5;
        c_in = 16'hAAAA; tick();
        c_in = 16'h5555; tick();
        write = 1'b0; hold = 1'b0;
        tick();
        checks++; if (reg_of(5) !== 16'hAAAA) begin errors++; $display("FAIL order_first: got %h expected AAAA", reg_of(5)); end
        tick();
        checks++; if (reg_of(5) !== 16'h5555) begin errors++; $display("FAIL order_last: got %h expected 5555", reg_of(5)); end
    endtask

`ifdef REGFILE_WR_BYPASS_EN
    task automatic test_bypass();
        hold = 1'b1; write = 1'b1; vsel = 2'b00; writenum = 3'd6;
        c_in = 16'h0001; tick();
        c_in = 16'h0002; tick();
        write = 1'b0;
        rd_num = 3'd6; #1;
        checks++; if (rd_data !== 16'h0002) begin errors++; $display("FAIL bypass_tail: got %h expected 0002", rd_data); end
        checks++; if (reg_of(6) !== 16'h0000) begin errors++; $display("FAIL bypass_reg6: got %h expected 0000", reg_of(6)); end
        rd_num = 3'd7; #1;
        checks++; if (rd_data !== exp_regs[7]) begin errors++; $display("FAIL bypass_miss: got %h expected %h", rd_data, exp_regs[7]); end
        hold = 1'b0;
        tick();
        rd_num = 3'd6; #1;
        checks++; if (rd_data !== 16'h0002) begin errors++; $display("FAIL bypass_head: got %h expected 0002", rd_data); end
        tick();
        checks++; if (reg_of(6) !== 16'h0002) begin errors++; $display("FAIL bypass_commit: got %h expected 0002", reg_of(6)); end
    endtask
`endif

    task automatic test_back_to_back();
        int start_commits;
        start_commits = commits;
        hold = 1'b0; write = 1'b1; vsel = 2'b00;
        for (int i = 0; i < 32; i++) begin
            writenum = 3'(i);
            c_in     = 16'h1000 + 16'(i);
            tick();
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, wr_ready); end
            checks++; if (regs !== exp_flat()) begin errors++; $display("FAIL stream_regs[%0d]: got %h expected %h", i, regs, exp_flat()); end
        end
        write = 1'b0;
        tick();
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL stream_pending: got %b expected 0", pending); end
        checks++; if (reg_of(7) !== 16'h101F) begin errors++; $display("FAIL stream_last: got %h expected 101F", reg_of(7)); end
        checks++; if (reg_of(0) !== 16'h1018) begin errors++; $display("FAIL stream_r0: got %h expected 1018", reg_of(0)); end
        checks++; if (commits - start_commits != 32) begin errors++; $display("FAIL stream_commits: got %0d expected 32", commits - start_commits); end
    endtask

    task automatic test_reset_mid();
        hold = 1'b1; write = 1'b1; vsel = 2'b00;
        writenum = 3'd2; c_in = 16'hC0DE; tick();
        writenum = 3'd3; c_in = 16'hD00D; tick();
        write = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (regs !== 128'h0) begin errors++; $display("FAIL midreset_regs: got %h expected 0", regs); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL midreset_pending: got %b expected 0", pending); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", wr_ready); end
        clear_model();
        @(negedge clk);
        resetn = 1'b1;
        hold = 1'b0;
        tick(); tick();
        checks++; if (regs !== 128'h0) begin errors++; $display("FAIL midreset_discard: got %h expected 0", regs); end
    endtask

    initial begin
        resetn = 1'b0; write = 1'b0; writenum = 3'd0; vsel = 2'b00;
        c_in = 16'h0; pc = 8'h0; imm8 = 8'h0; mdata = 16'h0; hold = 1'b0;
`ifdef REGFILE_WR_BYPASS_EN
        rd_num = 3'd0;
`endif
        test_reset();
        test_vsel();
        test_hold_full();
        test_same_reg();
`ifdef REGFILE_WR_BYPASS_EN
        test_bypass();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write.md
# regfile_write

Write-back side of the CPU register file: selects the write-back value by `vsel`, buffers up to two pending writes in a small queue, and commits them one per cycle into the eight 16-bit general registers. The registers are exported as a flat bus to the read side, which latches operands into A/B. A `hold` input lets the read side freeze commits while it samples operands.

## Interface
Parameters:
- `WIDTH`, 16: register and data width; must be ≥ 8.

Ports:
- `clk`, in, 1: the only clock; all state updates on its rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `write`, in, 1: write request; a write is accepted when `write && wr_ready`.
- `writenum`, in, 3: destination register index, 0–7.
- `vsel`, in, 2: source select.
  - 00: `c_in`.
  - 01: `pc`, zero-extended.
  - 10: `imm8`, sign-extended.
  - 11: `mdata`.
- `c_in`, in, WIDTH: datapath result.
- `pc`, in, 8: program counter.
- `imm8`, in, 8: immediate.
- `mdata`, in, WIDTH: memory read data.
- `hold`, in, 1: when 1, no commit occurs this cycle.
- `wr_ready`, out, 1: queue can accept a write.
- `pending`, out, 1: queue is non-empty.
- `regs`, out, 8*WIDTH: register array; `regs[i*WIDTH +: WIDTH]` is reg i.
- `rd_num`, in, 3: bypass read index. Present only with `REGFILE_WR_BYPASS_EN`.
- `rd_data`, out, WIDTH: bypass read data. Present only with `REGFILE_WR_BYPASS_EN`.

## Operation
- Source mux is combinational. The selected value and `writenum` are captured at the acceptance edge; later changes to the inputs do not affect a queued entry.
- Queue FSM states, with occupancy held as a 2-bit count:
  - EMPTY (0) → ONE on push.
  - ONE (1) → EMPTY on commit without push; → FULL on push without commit; stays ONE on push and commit together.
  - FULL (2) → ONE on commit. No push is possible in FULL.
- `wr_ready` = (state != FULL). It depends only on registered state. A push is never accepted while FULL, even if a commit happens in the same cycle.
- Commit occurs when `!hold && state != EMPTY`. The head entry is written into `regs[head.num]` and popped at that edge. Only one commit happens per cycle.
- Order is FIFO. Two queued writes to the same register commit in order, so the last one wins.
- A push into EMPTY is not committed on the same edge. Commit happens on the following edge at the earliest.
- `pending` = (state != EMPTY).
- `hold` has no effect on acceptance. Writes are still accepted until the queue is FULL.
- Reset, asynchronous and mid-operation:
  - All registers clear to 0.
  - The queue is emptied and its in-flight entries are discarded.
  - Outputs go to `wr_ready`=1, `pending`=0, `regs`=0.
- Sign extension: `imm8[7]` replicated into bits WIDTH-1:8. Zero extension: bits WIDTH-1:8 = 0.

## Timing
- Write accepted at edge N with `hold`=0 at edge N+1: the value is visible on `regs` after edge N+1. Latency is 1 cycle after acceptance.
- Each extra cycle of `hold` adds one cycle of latency.
- Sustained throughput is 1 write per cycle when `hold`=0: the queue alternates between accepting and committing in state ONE.
- `regs` is a registered output. `rd_data` is combinational from `regs`, the queue contents and `rd_num`.

## Configuration
- `REGFILE_WR_BYPASS_EN` defined:
  - `rd_num` and `rd_data` ports exist.
  - `rd_data` returns the youngest queued entry whose num matches `rd_num`, with tail taking priority over head.
  - If no queued entry matches, `rd_data` = `regs[rd_num]`.
  - Entries being pushed in the current cycle are not forwarded.
- Not defined: the ports are absent. The read side sees only committed values through `regs`.

## Structure
- Package `regfile_pkg` holds:
  - `WIDTH_DEFAULT` = 16.
  - `vsel` encodings: `VSEL_C`, `VSEL_PC`, `VSEL_IMM`, `VSEL_MDATA`.
  - Queue state encoding: `Q_EMPTY`, `Q_ONE`, `Q_FULL`.
  - Typedef `wq_entry_t` = {num[2:0], data[WIDTH-1:0]}.
- Sub-module `regfile_wq` is the 2-entry queue.
  - Push/pop interface; exposes head, tail and the state.
  - Parent holds the source mux, the register array and the bypass logic.

## Test plan
- Reset then idle: `regs`=0, `wr_ready`=1, `pending`=0. Assert `resetn`=0 mid-stream after 2 pushes: queue empties and regs clear to 0 immediately (no clock edge needed).
- `write`=1, `writenum`=3, `vsel`=10, `imm8`=8'hF0, `hold`=0: reg3 = 16'hFFF0 one edge after acceptance. Same with `vsel`=01, `pc`=8'h85: 16'h0085.
- `hold`=1, then three back-to-back writes: r1←16'h1111, r2←16'h2222, r4←16'h4444.
  - First two accepted; `wr_ready`=0 for the third.
  - Release `hold`: r1 commits, then r2 commits. The third write is accepted only once `wr_ready` is 1 again.
- Two writes to r5 (16'hAAAA then 16'h5555) under `hold`, then release: r5 ends at 16'h5555, and commits are observed in order.
- Bypass build: queue r6←16'h0001 then r6←16'h0002 under `hold`, with `rd_num`=6: `rd_data`=16'h0002 while `regs` r6 is still 0. With `rd_num`=7: `rd_data`=`regs` r7.
- Continuous writes with `vsel`=00 and incrementing `c_in` on every cycle, `hold`=0: `wr_ready` stays 1, one commit per cycle, no value lost over 32 writes.
